// File: rtl/stbuf_tcm_port.sv
// Store buffer in front of the TCM store-buffer port: in-order FIFO drain onto the
// write channel, plus loads whose TCM read data is merged with younger pending stores.
module stbuf_tcm_port #(
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int SIZE_WIDTH     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [ADDR_WIDTH-1:0]     push_addr,
    input  logic [SIZE_WIDTH-1:0]     push_size,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      drain_en,
    input  logic                      ld_valid,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [SIZE_WIDTH-1:0]     ld_size,
    output logic                      ld_resp_valid,
    output logic [DATA_WIDTH-1:0]     ld_resp_data,
    output logic [DATA_WIDTH/8-1:0]   ld_fwd_mask,
    output logic                      empty,
    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_write_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_write_size,
    output logic [DATA_WIDTH-1:0]     bus_tcm_stbuf_data,
    output logic                      bus_tcm_stbuf_wr,
    output logic [ADDR_WIDTH-1:0]     bus_tcm_stbuf_read_addr,
    output logic [SIZE_WIDTH-1:0]     bus_tcm_stbuf_read_size,
    output logic                      bus_tcm_stbuf_rd,
    input  logic [BUS_DATA_WIDTH-1:0] tcm_bus_stbuf_data
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [NB-1:0] size_to_mask(input logic [SIZE_WIDTH-1:0] size);
        case (32'(size))
            1:       return NB'(1);
            2:       return NB'(3);
            4:       return NB'(15);
            default: return '0;
        endcase
    endfunction

    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
    logic [SIZE_WIDTH-1:0] ent_size [DEPTH];
    logic [DATA_WIDTH-1:0] ent_data [DEPTH];
    logic [NB-1:0]         ent_mask [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;
    logic [PTR_W-1:0] slot [DEPTH];
    logic [NB-1:0]    push_mask;
    logic [NB-1:0]    ld_byte_en;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [NB-1:0]         fwd_hit;

    logic                  vld_p1;
    logic [NB-1:0]         fwd_hit_p1;
    logic [NB-1:0]         byte_en_p1;
    logic [DATA_WIDTH-1:0] fwd_data_p1;

    assign push_ready = rst && (count < CNT_W'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign do_pop     = rst && drain_en && (count != '0);
    assign empty      = (count == '0);
    assign push_mask  = size_to_mask(push_size);

    assign bus_tcm_stbuf_wr         = do_pop;
    assign bus_tcm_stbuf_write_addr = do_pop ? ent_addr[head] : '0;
    assign bus_tcm_stbuf_write_size = do_pop ? ent_size[head] : '0;
    assign bus_tcm_stbuf_data       = do_pop ? ent_data[head] : '0;

    assign bus_tcm_stbuf_rd        = rst && ld_valid;
    assign bus_tcm_stbuf_read_addr = bus_tcm_stbuf_rd ? ld_addr : '0;
    assign bus_tcm_stbuf_read_size = bus_tcm_stbuf_rd ? ld_size : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            ent_addr[tail] <= push_addr;
            ent_size[tail] <= push_size;
            ent_data[tail] <= push_data;
            ent_mask[tail] <= push_mask;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) slot[i] = head + PTR_W'(i);
        for (int k = 0; k < NB; k++) ld_byte_en[k] = (32'(ld_size) > 32'(k));
    end

    // Scan oldest to youngest so later matches overwrite earlier ones; the pushing store goes last.
    always_comb begin
        fwd_data = '0;
        fwd_hit  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                for (int k = 0; k < NB; k++) begin
                    for (int j = 0; j < NB; j++) begin
                        if (ld_byte_en[k] && ent_mask[slot[i]][j] &&
                            (ent_addr[slot[i]] + ADDR_WIDTH'(j) == ld_addr + ADDR_WIDTH'(k))) begin
                            fwd_data[8*k +: 8] = ent_data[slot[i]][8*j +: 8];
                            fwd_hit[k]         = 1'b1;
                        end
                    end
                end
            end
        end
        if (do_push) begin
            for (int k = 0; k < NB; k++) begin
                for (int j = 0; j < NB; j++) begin
                    if (ld_byte_en[k] && push_mask[j] &&
                        (push_addr + ADDR_WIDTH'(j) == ld_addr + ADDR_WIDTH'(k))) begin
                        fwd_data[8*k +: 8] = push_data[8*j +: 8];
                        fwd_hit[k]         = 1'b1;
                    end
                end
            end
        end
    end

    // Stage p1: forwarding snapshot held while the TCM read data returns
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1     <= 1'b0;
            fwd_hit_p1 <= '0;
        end else begin
            vld_p1     <= ld_valid;
            fwd_hit_p1 <= ld_valid ? fwd_hit : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_valid) begin
            fwd_data_p1 <= fwd_data;
            byte_en_p1  <= ld_byte_en;
        end
    end

    assign ld_resp_valid = rst && vld_p1;

    always_comb begin
        ld_resp_data = '0;
        ld_fwd_mask  = '0;
        if (ld_resp_valid) begin
            ld_fwd_mask = fwd_hit_p1;
            for (int k = 0; k < NB; k++) begin
                if (byte_en_p1[k])
                    ld_resp_data[8*k +: 8] = fwd_hit_p1[k] ? fwd_data_p1[8*k +: 8]
                                                           : tcm_bus_stbuf_data[8*k +: 8];
            end
        end
    end

    generate
        if (BUS_DATA_WIDTH > DATA_WIDTH) begin : g_bus_upper
            logic unused_bus_upper;
            assign unused_bus_upper = ^tcm_bus_stbuf_data[BUS_DATA_WIDTH-1:DATA_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_stbuf_tcm_port.sv
// Scoreboard bench for stbuf_tcm_port: stimulus queues expected writes, load responses
// and status values; a negedge monitor pops and compares them against the DUT.
module tb_stbuf_tcm_port;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 64;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [AW-1:0] push_addr = '0;
    logic [SW-1:0] push_size = '0;
    logic [DW-1:0] push_data = '0;
    logic          drain_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [SW-1:0] ld_size = '0;
    logic          ld_resp_valid;
    logic [DW-1:0] ld_resp_data;
    logic [3:0]    ld_fwd_mask;
    logic          empty;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] wr_size;
    logic [DW-1:0] wr_data;
    logic          bus_wr;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_size;
    logic          bus_rd;
    logic [BW-1:0] tcm_data = '0;

    always #5 clk = ~clk;

    stbuf_tcm_port #(.DEPTH(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .BUS_DATA_WIDTH(BW), .SIZE_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_size(push_size), .push_data(push_data),
        .drain_en(drain_en),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_fwd_mask(ld_fwd_mask),
        .empty(empty),
        .bus_tcm_stbuf_write_addr(wr_addr), .bus_tcm_stbuf_write_size(wr_size),
        .bus_tcm_stbuf_data(wr_data), .bus_tcm_stbuf_wr(bus_wr),
        .bus_tcm_stbuf_read_addr(rd_addr), .bus_tcm_stbuf_read_size(rd_size),
        .bus_tcm_stbuf_rd(bus_rd),
        .tcm_bus_stbuf_data(tcm_data)
    );

    typedef struct { logic [AW-1:0] addr; logic [SW-1:0] size; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; logic [3:0] mask; } ld_t;
    typedef struct { int sig; logic [31:0] val; } st_t;

    wr_t wq[$];
    ld_t lq[$];
    st_t sq[$];
    int  checks = 0;
    int  failures = 0;
    bit  done = 1'b0;

    // TCM read model: upper half is garbage that must never reach the load result
    function automatic logic [BW-1:0] tcm_word(input logic [AW-1:0] a);
        if (a == 32'h200) return 64'hFFFF_FFFF_1122_3344;
        return 64'hFFFF_FFFF_0BAD_F00D;
    endfunction

    always @(posedge clk) begin
        if (bus_rd) tcm_data <= tcm_word(rd_addr);
    end

    function automatic logic [31:0] sample(input int id);
        case (id)
            0: return 32'(push_ready);
            1: return 32'(empty);
            2: return 32'(ld_resp_valid);
            3: return 32'(bus_wr);
            4: return 32'(bus_rd);
            5: return ld_resp_data;
            6: return 32'(ld_fwd_mask);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic string sname(input int id);
        case (id)
            0: return "push_ready";
            1: return "empty";
            2: return "ld_resp_valid";
            3: return "tcm_wr";
            4: return "tcm_rd";
            5: return "ld_resp_data";
            6: return "ld_fwd_mask";
            default: return "unknown";
        endcase
    endfunction

    always @(negedge clk) begin
        st_t s;
        wr_t w;
        ld_t l;
        logic [31:0] act;
        while (sq.size() > 0) begin
            s = sq.pop_front();
            act = sample(s.sig);
            checks++;
            if (act !== s.val) begin
                failures++;
                $display("FAIL %s actual=%h required=%h t=%0t", sname(s.sig), act, s.val, $time);
            end
        end
        if (bus_wr) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual addr=%h data=%h required none t=%0t",
                         wr_addr, wr_data, $time);
            end else begin
                w = wq.pop_front();
                if (wr_addr !== w.addr || wr_size !== w.size || wr_data !== w.data) begin
                    failures++;
                    $display("FAIL tcm_write actual=%h/%0d/%h required=%h/%0d/%h t=%0t",
                             wr_addr, wr_size, wr_data, w.addr, w.size, w.data, $time);
                end
            end
        end
        if (ld_resp_valid) begin
            checks++;
            if (lq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_load_resp actual data=%h required none t=%0t",
                         ld_resp_data, $time);
            end else begin
                l = lq.pop_front();
                if (ld_resp_data !== l.data || ld_fwd_mask !== l.mask) begin
                    failures++;
                    $display("FAIL load_resp actual=%h/%b required=%h/%b t=%0t",
                             ld_resp_data, ld_fwd_mask, l.data, l.mask, $time);
                end
            end
        end
        if (done) begin
            checks++;
            if (wq.size() != 0) begin
                failures++;
                $display("FAIL writes_outstanding actual=%0d required=0", wq.size());
            end
            checks++;
            if (lq.size() != 0) begin
                failures++;
                $display("FAIL loads_outstanding actual=%0d required=0", lq.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_st(input int id, input logic [31:0] v);
        st_t s;
        s.sig = id;
        s.val = v;
        sq.push_back(s);
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [SW-1:0] sz, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.size = sz;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic exp_ld(input logic [DW-1:0] d, input logic [3:0] m);
        ld_t l;
        l.data = d;
        l.mask = m;
        lq.push_back(l);
    endtask

    task automatic set_push(input logic [AW-1:0] a, input logic [SW-1:0] sz, input logic [DW-1:0] d);
        push_valid = 1'b1;
        push_addr  = a;
        push_size  = sz;
        push_data  = d;
    endtask

    task automatic set_load(input logic [AW-1:0] a, input logic [SW-1:0] sz);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_size  = sz;
    endtask

    initial begin
        step();
        step();
        exp_st(0, 0); exp_st(1, 1); exp_st(2, 0); exp_st(3, 0);
        exp_st(4, 0); exp_st(5, 0); exp_st(6, 0);
        step();
        rst = 1'b1;
        exp_st(0, 1); exp_st(1, 1);
        step();

        // fill and drain
        for (int i = 0; i < 8; i++) begin
            set_push(AW'(32'h100 + 4 * i), 3'd4, DW'(32'hA0 + i));
            exp_wr(AW'(32'h100 + 4 * i), 3'd4, DW'(32'hA0 + i));
            exp_st(3, 0);
            step();
        end
        push_valid = 1'b0;
        exp_st(0, 0); exp_st(1, 0);
        step();
        drain_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_st(3, 1);
            step();
        end
        drain_en = 1'b0;
        exp_st(1, 1); exp_st(0, 1); exp_st(3, 0);
        step();

        // byte forward from a pending size-1 store
        set_push(32'h200, 3'd1, 32'h5A);
        step();
        push_valid = 1'b0;
        set_load(32'h200, 3'd4);
        exp_ld(32'h1122_335A, 4'b0001);
        exp_st(4, 1);
        step();
        ld_valid = 1'b0;
        exp_st(2, 1);
        step();
        exp_wr(32'h200, 3'd1, 32'h5A);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;

        // load on empty buffer, size 1: upper bytes forced to zero
        set_load(32'h200, 3'd1);
        exp_ld(32'h0000_0044, 4'b0000);
        step();
        ld_valid = 1'b0;
        step();

        // youngest store wins
        set_push(32'h300, 3'd4, 32'hAAAA_AAAA);
        step();
        set_push(32'h302, 3'd2, 32'h0000_BBBB);
        step();
        push_valid = 1'b0;
        set_load(32'h300, 3'd4);
        exp_ld(32'hBBBB_AAAA, 4'b1111);
        step();
        ld_valid = 1'b0;
        step();
        exp_wr(32'h300, 3'd4, 32'hAAAA_AAAA);
        exp_wr(32'h302, 3'd2, 32'h0000_BBBB);
        drain_en = 1'b1;
        step();
        step();
        drain_en = 1'b0;
        exp_st(1, 1);
        step();

        // same-cycle push forwards into the load
        set_push(32'h400, 3'd2, 32'h0000_CAFE);
        set_load(32'h400, 3'd2);
        exp_ld(32'h0000_CAFE, 4'b0011);
        step();
        push_valid = 1'b0;
        ld_valid = 1'b0;
        step();
        exp_wr(32'h400, 3'd2, 32'h0000_CAFE);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;

        // illegal size: queued and drained unchanged, never forwards
        set_push(32'h500, 3'd3, 32'h1234_5678);
        step();
        push_valid = 1'b0;
        set_load(32'h500, 3'd4);
        exp_ld(32'h0BAD_F00D, 4'b0000);
        step();
        ld_valid = 1'b0;
        step();
        exp_wr(32'h500, 3'd3, 32'h1234_5678);
        drain_en = 1'b1;
        step();
        drain_en = 1'b0;

        // continuous push and drain across pointer wrap
        drain_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_push(AW'(32'h600 + 4 * i), 3'd4, DW'(32'hC000_0000 + i));
            exp_wr(AW'(32'h600 + 4 * i), 3'd4, DW'(32'hC000_0000 + i));
            exp_st(0, 1);
            if (i > 0) begin
                exp_st(1, 0);
                exp_st(3, 1);
            end
            step();
        end
        push_valid = 1'b0;
        exp_st(3, 1);
        step();
        drain_en = 1'b0;
        exp_st(1, 1); exp_st(3, 0);
        step();

        // reset with entries pending and a load in flight
        for (int i = 0; i < 3; i++) begin
            set_push(AW'(32'h800 + 4 * i), 3'd4, DW'(i));
            step();
        end
        push_valid = 1'b0;
        set_load(32'h800, 3'd4);
        step();
        ld_valid = 1'b0;
        rst = 1'b0;
        exp_st(2, 0); exp_st(3, 0);
        step();
        rst = 1'b1;
        exp_st(1, 1); exp_st(2, 0); exp_st(0, 1);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_st(3, 0);
            step();
        end
        drain_en = 1'b0;
        step();
        step();
        done = 1'b1;
    end

endmodule
